// File: rtl/z80_bus_ctrl_if.sv
// Core-side bus of the Z80 memory/IO controller: strobes, address, data and wait.
// master = the Z80 core pins, slave = the bus controller.
interface z80_bus_ctrl_if;
    logic [15:0] addr_bus;
    logic [7:0]  data_wr;
    logic [7:0]  data_rd;
    logic        data_oe;
    logic        MREQ_L;
    logic        IORQ_L;
    logic        RD_L;
    logic        WR_L;
    logic        M1_L;
    logic        WAIT_L;

    modport master (
        output addr_bus, data_wr, MREQ_L, IORQ_L, RD_L, WR_L, M1_L,
        input  data_rd, data_oe, WAIT_L
    );

    modport slave (
        input  addr_bus, data_wr, MREQ_L, IORQ_L, RD_L, WR_L, M1_L,
        output data_rd, data_oe, WAIT_L
    );
endinterface

// File: rtl/z80_bus_ctrl.sv
// Z80 bus controller: decodes core strobes into BRAM/IO accesses stretched with WAIT_L.
// Define Z80_BUS_CTRL_IO_EN to enable the IO handshake; otherwise IO reads return 8'hFF.
module z80_bus_ctrl #(
    parameter int          MEM_WAIT = 2,
    parameter logic [15:0] ROM_TOP  = 16'h0000,
    parameter int          IO_WAIT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    z80_bus_ctrl_if.slave        bus,
    output logic [15:0]          mem_addr,
    output logic [7:0]           mem_wdata,
    output logic                 mem_re,
    output logic                 mem_we,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           io_port,
    output logic [7:0]           io_wdata,
    output logic                 io_rd,
    output logic                 io_wr,
    input  logic [7:0]           io_rdata
);

    if (MEM_WAIT < 2 || MEM_WAIT > 15) begin : g_mem_wait_bad
        $error("z80_bus_ctrl: MEM_WAIT must be 2..15");
    end
    if (IO_WAIT < 1 || IO_WAIT > 15) begin : g_io_wait_bad
        $error("z80_bus_ctrl: IO_WAIT must be 1..15");
    end

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    typedef enum logic [1:0] {IDLE, MACC, IACC, HOLD} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        read_q, read_d;
    logic        wait_q, wait_d;
    logic        oe_q, oe_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [15:0] mem_addr_d;
    logic [7:0]  mem_wdata_d, io_port_d, io_wdata_d;
    logic        mem_re_d, mem_we_d, io_rd_d, io_wr_d;
    logic        any_rw, released;

    assign any_rw   = !bus.RD_L || !bus.WR_L;
    assign released = bus.RD_L && bus.WR_L && bus.MREQ_L && bus.IORQ_L;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            read_q    <= 1'b0;
            wait_q    <= 1'b1;
            oe_q      <= 1'b0;
            rd_data_q <= 8'h00;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            io_port   <= 8'h00;
            io_wdata  <= 8'h00;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            read_q    <= read_d;
            wait_q    <= wait_d;
            oe_q      <= oe_d;
            rd_data_q <= rd_data_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
            io_port   <= io_port_d;
            io_wdata  <= io_wdata_d;
            io_rd     <= io_rd_d;
            io_wr     <= io_wr_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        read_d      = read_q;
        wait_d      = wait_q;
        oe_d        = oe_q;
        rd_data_d   = rd_data_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        io_port_d   = io_port;
        io_wdata_d  = io_wdata;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        io_rd_d     = 1'b0;
        io_wr_d     = 1'b0;

        unique case (state)
            IDLE: begin
                oe_d = 1'b0;
                if (!bus.MREQ_L && any_rw) begin
                    state_d     = MACC;
                    cnt_d       = 4'd1;
                    read_d      = !bus.RD_L;
                    wait_d      = 1'b0;
                    mem_addr_d  = bus.addr_bus;
                    mem_wdata_d = bus.data_wr;
                    mem_re_d    = !bus.RD_L;
                    // Writes below ROM_TOP still run the full wait sequence, just without mem_we.
                    mem_we_d    = bus.RD_L && !(bus.addr_bus < ROM_TOP);
                end else if (!bus.IORQ_L && !bus.M1_L) begin
                    state_d   = HOLD;
                    rd_data_d = 8'hFF;
                    oe_d      = 1'b1;
                end else if (!bus.IORQ_L && any_rw) begin
`ifdef Z80_BUS_CTRL_IO_EN
                    state_d    = IACC;
                    cnt_d      = 4'd1;
                    read_d     = !bus.RD_L;
                    wait_d     = 1'b0;
                    io_port_d  = bus.addr_bus[7:0];
                    io_wdata_d = bus.data_wr;
                    io_rd_d    = !bus.RD_L;
                    io_wr_d    = bus.RD_L;
`else
                    state_d = HOLD;
                    if (!bus.RD_L) begin
                        rd_data_d = 8'hFF;
                        oe_d      = 1'b1;
                    end
`endif
                end
            end
            MACC: begin
                if (read_q && cnt == 4'd2) begin
                    rd_data_d = mem_rdata;
                end
                if (cnt == MEM_WAIT_C) begin
                    state_d = HOLD;
                    wait_d  = 1'b1;
                    oe_d    = read_q;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            IACC: begin
                if (read_q && cnt == 4'd1) begin
                    rd_data_d = io_rdata;
                end
                if (cnt == IO_WAIT_C) begin
                    state_d = HOLD;
                    wait_d  = 1'b1;
                    oe_d    = read_q;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (released) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.WAIT_L  = wait_q;
    assign bus.data_oe = oe_q;
    assign bus.data_rd = rd_data_q;

endmodule
